trap_ctrl: RTL and testbench

//  Machine-mode interrupt/MRET sequencer in the 3-stage pipeline, between execute and csr_reg.

---
 rtl/trap_pkg.sv | 50 +++++
 rtl/trap_ctrl_if.sv | 38 +++
 rtl/irq_sync.sv | 23 ++
 rtl/trap_ctrl.sv | 166 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared CSR addresses, cause codes, mstatus/mie bit positions and the
// sequencer state encoding for the machine-mode trap controller.
package trap_pkg;

    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MIE     = 32'h0000_0304;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MIP     = 32'h0000_0344;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    localparam int MST_MIE  = 3;
    localparam int MST_MPIE = 7;
    localparam int MIE_MTIE = 7;
    localparam int MIE_MEIE = 11;

    // mepc is always word aligned
    localparam logic [31:0] EPC_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_STAT,
        T_MIP,
        T_JMP,
        R_RD,
        R_STAT,
        R_JMP
    } state_e;

    // Trap entry: stash MIE into MPIE and mask interrupts.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] mst);
        logic [31:0] r;
        r           = mst;
        r[MST_MPIE] = mst[MST_MIE];
        r[MST_MIE]  = 1'b0;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE and set MPIE.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] mst);
        logic [31:0] r;
        r           = mst;
        r[MST_MIE]  = mst[MST_MPIE];
        r[MST_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-side bundle of the trap controller; master is the controller,
// slave is the execute stage plus csr_reg that surround it.
interface trap_ctrl_if;

    logic        irq_ext_i;
    logic        irq_timer_i;
    logic        instr_valid_i;
    logic [31:0] pc_i;
    logic        mret_i;
    logic        snp_wr_i;
    logic [31:0] snp_addr_i;
    logic [31:0] snp_data_i;
    logic [31:0] csr_rdata_i;
    logic        csr_own_o;
    logic [31:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_red_o;
    logic        csr_write_o;
    logic        stall_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    modport master (
        input  irq_ext_i, irq_timer_i, instr_valid_i, pc_i, mret_i,
        input  snp_wr_i, snp_addr_i, snp_data_i, csr_rdata_i,
        output csr_own_o, csr_addr_o, csr_wdata_o, csr_red_o, csr_write_o,
        output stall_o, flush_o, redirect_o, redirect_pc_o
    );

    modport slave (
        output irq_ext_i, irq_timer_i, instr_valid_i, pc_i, mret_i,
        output snp_wr_i, snp_addr_i, snp_data_i, csr_rdata_i,
        input  csr_own_o, csr_addr_o, csr_wdata_o, csr_red_o, csr_write_o,
        input  stall_o, flush_o, redirect_o, redirect_pc_o
    );

endinterface

// File: rtl/irq_sync.sv
// Multi-flop synchronizer bringing one asynchronous level IRQ into the clock domain.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode interrupt entry / MRET sequencer. Borrows csr_reg's single port
// for a few cycles, stalls the pipeline, and finishes with a flush+redirect.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [31:0] MTVEC_BASE  = 32'h0000_0100,
    parameter bit          VECTORED    = 1'b0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic         clock,
    input  logic         reset,
    trap_ctrl_if.master  bus
);

    // index 1 = external, index 0 = timer
    logic [1:0] irq_raw;
    logic [1:0] irq_sync_q;

    assign irq_raw = {bus.irq_ext_i, bus.irq_timer_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_irq_sync
        irq_sync #(
            .STAGES (SYNC_STAGES)
        ) u_irq_sync (
            .clock (clock),
            .reset (reset),
            .d     (irq_raw[gi]),
            .q     (irq_sync_q[gi])
        );
    end

    state_e      state_reg;
    logic [31:0] epc_q;
    logic [3:0]  cause_q;
    logic [31:0] mip_q;
    logic [31:0] mst_q;
    logic [1:0]  mie_q;          // {MEIE, MTIE}; other mie bits never matter here
    logic [31:0] csr_addr_reg;
    logic [31:0] csr_wdata_reg;
    logic        csr_red_reg;
    logic        csr_write_reg;
    logic        redirect_reg;
    logic [31:0] redirect_pc_reg;

    logic [1:0]  pend;
    logic        idle;
    logic        take;
    logic        mret_go;
    logic [31:0] mip_next;
    logic [31:0] trap_target;

    assign idle    = (state_reg == IDLE);
    assign pend    = irq_sync_q & mie_q;
    assign take    = idle & bus.instr_valid_i & mst_q[MST_MIE] & (|pend);
    // An interrupt wins over an MRET in the same cycle; the MRET re-executes later.
    assign mret_go = idle & bus.instr_valid_i & bus.mret_i & ~take;

    always_comb begin
        mip_next           = '0;
        mip_next[MIE_MEIE] = irq_sync_q[1];
        mip_next[MIE_MTIE] = irq_sync_q[0];
    end

    assign trap_target = VECTORED ? (MTVEC_BASE + {26'd0, cause_q, 2'b00}) : MTVEC_BASE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            epc_q           <= '0;
            cause_q         <= '0;
            mip_q           <= '0;
            mst_q           <= '0;
            mie_q           <= '0;
            csr_addr_reg    <= '0;
            csr_wdata_reg   <= '0;
            csr_red_reg     <= 1'b0;
            csr_write_reg   <= 1'b0;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            // Every output is a one-state pulse unless the next state re-asserts it.
            csr_addr_reg    <= '0;
            csr_wdata_reg   <= '0;
            csr_red_reg     <= 1'b0;
            csr_write_reg   <= 1'b0;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;

            case (state_reg)
                IDLE: begin
                    if (bus.snp_wr_i && bus.snp_addr_i == CSR_MSTATUS) begin
                        mst_q <= bus.snp_data_i;
                    end
                    if (bus.snp_wr_i && bus.snp_addr_i == CSR_MIE) begin
                        mie_q <= {bus.snp_data_i[MIE_MEIE], bus.snp_data_i[MIE_MTIE]};
                    end
                    if (take) begin
                        epc_q         <= bus.pc_i & EPC_MASK;
                        cause_q       <= pend[1] ? CAUSE_MEI : CAUSE_MTI;
                        mip_q         <= mip_next;
                        state_reg     <= T_EPC;
                        csr_addr_reg  <= CSR_MEPC;
                        csr_wdata_reg <= bus.pc_i & EPC_MASK;
                        csr_write_reg <= 1'b1;
                    end else if (mret_go) begin
                        state_reg    <= R_RD;
                        csr_addr_reg <= CSR_MEPC;
                        csr_red_reg  <= 1'b1;
                    end
                end
                T_EPC: begin
                    state_reg     <= T_STAT;
                    mst_q         <= trap_mstatus(mst_q);
                    csr_addr_reg  <= CSR_MSTATUS;
                    csr_wdata_reg <= trap_mstatus(mst_q);
                    csr_write_reg <= 1'b1;
                end
                T_STAT: begin
                    state_reg     <= T_MIP;
                    csr_addr_reg  <= CSR_MIP;
                    csr_wdata_reg <= mip_q;
                    csr_write_reg <= 1'b1;
                end
                T_MIP: begin
                    state_reg       <= T_JMP;
                    redirect_reg    <= 1'b1;
                    redirect_pc_reg <= trap_target;
                end
                T_JMP: begin
                    state_reg <= IDLE;
                end
                R_RD: begin
                    // csr_reg answers the read combinationally while csr_red_o is high
                    epc_q         <= bus.csr_rdata_i & EPC_MASK;
                    state_reg     <= R_STAT;
                    mst_q         <= mret_mstatus(mst_q);
                    csr_addr_reg  <= CSR_MSTATUS;
                    csr_wdata_reg <= mret_mstatus(mst_q);
                    csr_write_reg <= 1'b1;
                end
                R_STAT: begin
                    state_reg       <= R_JMP;
                    redirect_reg    <= 1'b1;
                    redirect_pc_reg <= epc_q;
                end
                R_JMP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.csr_own_o     = ~idle;
    assign bus.csr_addr_o    = csr_addr_reg;
    assign bus.csr_wdata_o   = csr_wdata_reg;
    assign bus.csr_red_o     = csr_red_reg;
    assign bus.csr_write_o   = csr_write_reg;
    assign bus.stall_o       = take | mret_go | ~idle;
    assign bus.flush_o       = redirect_reg;
    assign bus.redirect_o    = redirect_reg;
    assign bus.redirect_pc_o = redirect_pc_reg;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a direct-vector and a vectored instance share
// stimulus; expected CSR/redirect events are queued per instance and popped by a monitor.
module tb_trap_ctrl;

    typedef struct packed {
        logic [5:0]  flags;   // {own, stall, flush, red, write, redirect}
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        irq_ext = 1'b0;
    logic        irq_timer = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        mret = 1'b0;
    logic        snp_wr = 1'b0;
    logic [31:0] snp_addr = '0;
    logic [31:0] snp_data = '0;
    logic [31:0] csr_rdata = '0;

    int checks = 0;
    int failures = 0;

    ev_t exp_q0[$];
    ev_t exp_q1[$];

    always #5 clock = ~clock;

    trap_ctrl_if bus0 ();
    trap_ctrl_if bus1 ();

    assign bus0.irq_ext_i = irq_ext;       assign bus1.irq_ext_i = irq_ext;
    assign bus0.irq_timer_i = irq_timer;   assign bus1.irq_timer_i = irq_timer;
    assign bus0.instr_valid_i = instr_valid; assign bus1.instr_valid_i = instr_valid;
    assign bus0.pc_i = pc;                 assign bus1.pc_i = pc;
    assign bus0.mret_i = mret;             assign bus1.mret_i = mret;
    assign bus0.snp_wr_i = snp_wr;         assign bus1.snp_wr_i = snp_wr;
    assign bus0.snp_addr_i = snp_addr;     assign bus1.snp_addr_i = snp_addr;
    assign bus0.snp_data_i = snp_data;     assign bus1.snp_data_i = snp_data;
    assign bus0.csr_rdata_i = csr_rdata;   assign bus1.csr_rdata_i = csr_rdata;

    trap_ctrl #(.MTVEC_BASE(32'h100), .VECTORED(1'b0), .SYNC_STAGES(2)) dut0 (
        .clock (clock), .reset (reset), .bus (bus0)
    );
    trap_ctrl #(.MTVEC_BASE(32'h100), .VECTORED(1'b1), .SYNC_STAGES(2)) dut1 (
        .clock (clock), .reset (reset), .bus (bus1)
    );

    function automatic ev_t ev_wr(input logic [31:0] a, input logic [31:0] d);
        ev_t e; e.flags = 6'b110010; e.addr = a; e.data = d; return e;
    endfunction
    function automatic ev_t ev_rd(input logic [31:0] a);
        ev_t e; e.flags = 6'b110100; e.addr = a; e.data = '0; return e;
    endfunction
    function automatic ev_t ev_jmp(input logic [31:0] p);
        ev_t e; e.flags = 6'b111001; e.addr = '0; e.data = p; return e;
    endfunction
    function automatic logic [31:0] tgt(input bit vec, input int cause);
        return vec ? 32'h100 + 32'(cause * 4) : 32'h100;
    endfunction

    // Queue the same trap-entry sequence for both instances.
    task automatic push_trap(input logic [31:0] epc, input logic [31:0] mst_w,
                             input logic [31:0] mip, input int cause);
        exp_q0.push_back(ev_wr(32'h341, epc));   exp_q1.push_back(ev_wr(32'h341, epc));
        exp_q0.push_back(ev_wr(32'h300, mst_w)); exp_q1.push_back(ev_wr(32'h300, mst_w));
        exp_q0.push_back(ev_wr(32'h344, mip));   exp_q1.push_back(ev_wr(32'h344, mip));
        exp_q0.push_back(ev_jmp(tgt(1'b0, cause)));
        exp_q1.push_back(ev_jmp(tgt(1'b1, cause)));
    endtask

    task automatic push_mret(input logic [31:0] mst_w, input logic [31:0] epc);
        exp_q0.push_back(ev_rd(32'h341));        exp_q1.push_back(ev_rd(32'h341));
        exp_q0.push_back(ev_wr(32'h300, mst_w)); exp_q1.push_back(ev_wr(32'h300, mst_w));
        exp_q0.push_back(ev_jmp(epc));           exp_q1.push_back(ev_jmp(epc));
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic set_shadows(input logic [31:0] mst, input logic [31:0] mie);
        step(); snp_wr = 1'b1; snp_addr = 32'h300; snp_data = mst;
        step(); snp_addr = 32'h304; snp_data = mie;
        step(); snp_wr = 1'b0; snp_addr = '0; snp_data = '0;
    endtask

    task automatic wait_own(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            seen = bus0.csr_own_o;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) @(negedge clock);
        repeat (3) @(negedge clock);
    endtask

    // Monitor: every cycle with CSR or redirect activity is one transaction.
    always @(negedge clock) begin
        ev_t obs [2];
        ev_t exp;
        bit  have;
        logic [1:0] act;
        obs[0].flags = {bus0.csr_own_o, bus0.stall_o, bus0.flush_o, bus0.csr_red_o, bus0.csr_write_o, bus0.redirect_o};
        obs[0].addr  = bus0.csr_addr_o;
        obs[0].data  = bus0.csr_write_o ? bus0.csr_wdata_o : (bus0.redirect_o ? bus0.redirect_pc_o : '0);
        obs[1].flags = {bus1.csr_own_o, bus1.stall_o, bus1.flush_o, bus1.csr_red_o, bus1.csr_write_o, bus1.redirect_o};
        obs[1].addr  = bus1.csr_addr_o;
        obs[1].data  = bus1.csr_write_o ? bus1.csr_wdata_o : (bus1.redirect_o ? bus1.redirect_pc_o : '0);
        act[0] = |obs[0].flags[2:0];
        act[1] = |obs[1].flags[2:0];
        for (int k = 0; k < 2; k++) begin
            if (act[k]) begin
                have = 1'b0;
                exp  = '0;
                if (k == 0 && exp_q0.size() > 0) begin exp = exp_q0.pop_front(); have = 1'b1; end
                if (k == 1 && exp_q1.size() > 0) begin exp = exp_q1.pop_front(); have = 1'b1; end
                $display("t=%0t dut%0d txn flags=%b addr=%h data=%h", $time, k, obs[k].flags, obs[k].addr, obs[k].data);
                checks++;
                if (!have) begin
                    failures++;
                    $display("FAIL unexpected_txn dut%0d got flags=%b addr=%h data=%h required none",
                             k, obs[k].flags, obs[k].addr, obs[k].data);
                end else if (obs[k] !== exp) begin
                    failures++;
                    $display("FAIL txn dut%0d got flags=%b addr=%h data=%h required flags=%b addr=%h data=%h",
                             k, obs[k].flags, obs[k].addr, obs[k].data, exp.flags, exp.addr, exp.data);
                end
            end
        end
    end

    task automatic test_reset();
        logic [104:0] o0, o1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        o0 = {bus0.csr_own_o, bus0.stall_o, bus0.flush_o, bus0.csr_red_o, bus0.csr_write_o, bus0.redirect_o,
              bus0.csr_addr_o, bus0.csr_wdata_o, bus0.redirect_pc_o};
        o1 = {bus1.csr_own_o, bus1.stall_o, bus1.flush_o, bus1.csr_red_o, bus1.csr_write_o, bus1.redirect_o,
              bus1.csr_addr_o, bus1.csr_wdata_o, bus1.redirect_pc_o};
        checks++;
        if (o0 !== '0) begin failures++; $display("FAIL reset_outputs dut0 got %h required 0", o0); end
        checks++;
        if (o1 !== '0) begin failures++; $display("FAIL reset_outputs dut1 got %h required 0", o1); end
        step(); reset = 1'b1;
        step();
    endtask

    task automatic test_trap_ext();
        bit found = 1'b0;
        int lat = 0;
        set_shadows(32'h8, 32'h800);
        pc = 32'h40; instr_valid = 1'b1;
        push_trap(32'h40, 32'h80, 32'h800, 11);
        irq_ext = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            found = bus0.stall_o && !bus0.csr_own_o;
        end
        while (found && !bus0.redirect_o && lat < 10) begin
            @(negedge clock);
            lat++;
            if (lat == 1) begin irq_ext = 1'b0; instr_valid = 1'b0; end
        end
        checks++;
        if (!found || lat != 4) begin
            failures++;
            $display("FAIL trap_latency got found=%0d cycles=%0d required 4", found, lat);
        end
        irq_ext = 1'b0; instr_valid = 1'b0;
        wait_drain();
        checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            failures++;
            $display("FAIL trap_ext_drain got %0d pending required 0", exp_q0.size() + exp_q1.size());
            exp_q0.delete(); exp_q1.delete();
        end
    endtask

    task automatic test_vectored(input logic [31:0] mie, input logic ext, input logic tmr,
                                 input logic [31:0] mip, input int cause, input logic [31:0] p);
        bit seen;
        set_shadows(32'h8, mie);
        pc = p;
        push_trap(p, 32'h80, mip, cause);
        irq_ext = ext; irq_timer = tmr; instr_valid = 1'b1;
        wait_own(seen);
        irq_ext = 1'b0; irq_timer = 1'b0; instr_valid = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL vectored_take cause=%0d got no trap required trap", cause); end
        wait_drain();
        checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            failures++;
            $display("FAIL vectored_drain cause=%0d got %0d pending required 0", cause, exp_q0.size() + exp_q1.size());
            exp_q0.delete(); exp_q1.delete();
        end
    endtask

    task automatic test_masked();
        int busy0 = 0, busy1 = 0;
        set_shadows(32'h0, 32'h880);
        irq_ext = 1'b1; irq_timer = 1'b1; instr_valid = 1'b1; pc = 32'h50;
        repeat (20) begin
            @(negedge clock);
            if (bus0.stall_o || bus0.csr_own_o) busy0++;
            if (bus1.stall_o || bus1.csr_own_o) busy1++;
        end
        checks++;
        if (busy0 != 0) begin failures++; $display("FAIL masked_busy dut0 got %0d cycles required 0", busy0); end
        checks++;
        if (busy1 != 0) begin failures++; $display("FAIL masked_busy dut1 got %0d cycles required 0", busy1); end
        irq_ext = 1'b0; irq_timer = 1'b0; instr_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_mret();
        int own0 = 0, own1 = 0, stl0 = 0;
        set_shadows(32'h80, 32'h0);
        csr_rdata = 32'h44; pc = 32'h200;
        push_mret(32'h88, 32'h44);
        step(); mret = 1'b1; instr_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (bus0.stall_o !== 1'b1 || bus1.stall_o !== 1'b1) begin
            failures++;
            $display("FAIL mret_stall_issue got %b%b required 11", bus0.stall_o, bus1.stall_o);
        end
        step(); mret = 1'b0; instr_valid = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (bus0.csr_own_o) own0++;
            if (bus1.csr_own_o) own1++;
            if (bus0.stall_o) stl0++;
        end
        checks++;
        if (own0 != 3 || own1 != 3) begin
            failures++;
            $display("FAIL mret_own_cycles got %0d/%0d required 3/3", own0, own1);
        end
        checks++;
        if (stl0 != 3) begin failures++; $display("FAIL mret_stall_cycles got %0d required 3", stl0); end
        wait_drain();
        checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            failures++;
            $display("FAIL mret_drain got %0d pending required 0", exp_q0.size() + exp_q1.size());
            exp_q0.delete(); exp_q1.delete();
        end
    endtask

    task automatic test_irq_and_mret();
        bit seen;
        set_shadows(32'h8, 32'h800);
        irq_ext = 1'b1; instr_valid = 1'b0; pc = 32'h60;
        repeat (4) step();
        push_trap(32'h60, 32'h80, 32'h800, 11);
        mret = 1'b1; instr_valid = 1'b1;
        wait_own(seen);
        mret = 1'b0;
        checks++;
        if (!seen) begin failures++; $display("FAIL irq_mret_take got no sequence required trap"); end
        wait_drain();
        checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            failures++;
            $display("FAIL irq_mret_drain got %0d pending required 0", exp_q0.size() + exp_q1.size());
            exp_q0.delete(); exp_q1.delete();
        end
    endtask

    // IRQ still asserted and instr_valid held: MRET re-enables MIE and the core traps again.
    task automatic test_back_to_back();
        bit seen;
        csr_rdata = 32'h60; pc = 32'h60;
        push_mret(32'h88, 32'h60);
        push_trap(32'h60, 32'h80, 32'h800, 11);
        step(); mret = 1'b1;
        wait_own(seen);
        mret = 1'b0;
        wait_drain();
        checks++;
        if (!seen || exp_q0.size() + exp_q1.size() != 0) begin
            failures++;
            $display("FAIL back_to_back got started=%0d pending=%0d required 1/0", seen, exp_q0.size() + exp_q1.size());
            exp_q0.delete(); exp_q1.delete();
        end
        irq_ext = 1'b0; instr_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        logic [104:0] o0, o1;
        set_shadows(32'h8, 32'h800);
        pc = 32'h90; instr_valid = 1'b1;
        exp_q0.push_back(ev_wr(32'h341, 32'h90)); exp_q1.push_back(ev_wr(32'h341, 32'h90));
        exp_q0.push_back(ev_wr(32'h300, 32'h80)); exp_q1.push_back(ev_wr(32'h300, 32'h80));
        irq_ext = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clock);
            found = bus0.csr_write_o && bus0.csr_addr_o == 32'h300;
        end
        #1 reset = 1'b0; irq_ext = 1'b0; instr_valid = 1'b0;
        #1;
        o0 = {bus0.csr_own_o, bus0.stall_o, bus0.flush_o, bus0.csr_red_o, bus0.csr_write_o, bus0.redirect_o,
              bus0.csr_addr_o, bus0.csr_wdata_o, bus0.redirect_pc_o};
        o1 = {bus1.csr_own_o, bus1.stall_o, bus1.flush_o, bus1.csr_red_o, bus1.csr_write_o, bus1.redirect_o,
              bus1.csr_addr_o, bus1.csr_wdata_o, bus1.redirect_pc_o};
        checks++;
        if (!found || o0 !== '0) begin
            failures++;
            $display("FAIL reset_mid dut0 got found=%0d outputs=%h required 1/0", found, o0);
        end
        checks++;
        if (o1 !== '0) begin failures++; $display("FAIL reset_mid dut1 got %h required 0", o1); end
        repeat (2) step();
        reset = 1'b1;
        repeat (10) @(negedge clock);
        checks++;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_drain got %0d pending required 0", exp_q0.size() + exp_q1.size());
            exp_q0.delete(); exp_q1.delete();
        end
    endtask

    initial begin
        test_reset();
        test_trap_ext();
        test_vectored(32'h80, 1'b0, 1'b1, 32'h80, 7, 32'h80);
        test_vectored(32'h880, 1'b1, 1'b1, 32'h880, 11, 32'h84);
        test_masked();
        test_mret();
        test_irq_and_mret();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
